// File: rtl/regfile_wb_sched.sv
// ---------------------------------------------------------------------------
// regfile_wb_sched
//
// Write-back scheduler and storage controller for the Y86 register file.
// Up to two write-back requests per cycle (E path, then M path) are placed in
// an in-order pending queue. One queued write per cycle is committed into a
// single-write-port 15 x 64 register array. Two combinational read ports are
// served from committed storage, optionally bypassing from the pending queue.
// After reset the array is cleared one register per cycle before writes are
// accepted.
//
// Parameters:
//   DEPTH          pending-queue entries (2..8)
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   wb_valid_e     E-path write request; dstE / valE destination and data
//   wb_valid_m     M-path write request; dstM / valM destination and data
//   wb_ready       both write paths may present this cycle
//   srcA / srcB    read selects (4'hF = none); valA / valB read data
//   rd_hazard_a/b  read select matches a pending entry (bypass disabled only)
//   init_done      register clear complete
//   pend_cnt       current queue occupancy
//
// Build option:
//   RF_BYPASS_EN   defined: reads forward from the youngest matching pending
//                  entry and the hazard outputs are tied low.
//                  undefined: reads return committed storage only and the
//                  hazard outputs flag pending writes to the selected register.
// ---------------------------------------------------------------------------
module regfile_wb_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid_e,
    input  logic [3:0]  dstE,
    input  logic [63:0] valE,
    input  logic        wb_valid_m,
    input  logic [3:0]  dstM,
    input  logic [63:0] valM,
    output logic        wb_ready,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic        rd_hazard_a,
    output logic        rd_hazard_b,
    output logic        init_done,
    output logic [3:0]  pend_cnt
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [3:0]  dst;
        logic [63:0] val;
    } entry_t;

    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [3:0] LAST_REG  = 4'd14;
    localparam logic [3:0] READY_MAX = 4'(DEPTH - 2);

    state_t      state_q, state_d;
    logic [3:0]  clr_ptr_q, clr_ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    entry_t      queue_q [DEPTH];
    entry_t      queue_d [DEPTH];
    logic [63:0] regs_q  [15];

    logic        acc_e, acc_m, pop;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data;
    logic [3:0]  base_e, base_m;

    // Control: clear sequencing in INIT, one commit per cycle in RUN.
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wb_ready  = 1'b0;
        pop       = 1'b0;
        rf_we     = 1'b0;
        rf_addr   = clr_ptr_q;
        rf_data   = '0;
        case (state_q)
            ST_INIT: begin
                rf_we = 1'b1;
                if (clr_ptr_q == LAST_REG) state_d = ST_RUN;
                else                       clr_ptr_d = clr_ptr_q + 4'd1;
            end
            ST_RUN: begin
                wb_ready = (cnt_q <= READY_MAX);
                pop      = (cnt_q != 4'd0);
                rf_we    = pop;
                rf_addr  = queue_q[0].dst;
                rf_data  = queue_q[0].val;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Requests to register 4'hF are accepted but never enqueued.
    assign acc_e = wb_valid_e && wb_ready && (dstE != REG_NONE);
    assign acc_m = wb_valid_m && wb_ready && (dstM != REG_NONE);

    // Shift queue: slot 0 is the head. After an optional pop shifts everything
    // down, E lands in the first free slot and M right behind it, so M commits
    // last on an equal destination.
    assign base_e = cnt_q - 4'(pop);
    assign base_m = base_e + 4'(acc_e);
    assign cnt_d  = cnt_q - 4'(pop) + 4'(acc_e) + 4'(acc_m);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            queue_d[i] = queue_q[i];
            if (pop && i < DEPTH - 1) queue_d[i] = queue_q[i + 1];
            if (acc_e && base_e == 4'(i)) queue_d[i] = '{dst: dstE, val: valE};
            if (acc_m && base_m == 4'(i)) queue_d[i] = '{dst: dstM, val: valM};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // NOTE: queue payload and the register array carry no reset; occupancy
    // qualifies the queue and the INIT sweep clears the array, which keeps
    // both as plain storage with a single write port.
    always_ff @(posedge clk) begin
        queue_q <= queue_d;
        if (rst_n && rf_we) regs_q[rf_addr] <= rf_data;
    end

    assign init_done = (state_q == ST_RUN);
    assign pend_cnt  = cnt_q;

    // Read ports. Scanning oldest to youngest lets the youngest match win.
    logic hit_a, hit_b;
`ifdef RF_BYPASS_EN
    logic [63:0] byp_a, byp_b;
`endif

    always_comb begin
        hit_a       = 1'b0;
        hit_b       = 1'b0;
        valA        = '0;
        valB        = '0;
        rd_hazard_a = 1'b0;
        rd_hazard_b = 1'b0;
`ifdef RF_BYPASS_EN
        byp_a       = '0;
        byp_b       = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (4'(i) < cnt_q) begin
                if (queue_q[i].dst == srcA) begin
                    hit_a = 1'b1;
`ifdef RF_BYPASS_EN
                    byp_a = queue_q[i].val;
`endif
                end
                if (queue_q[i].dst == srcB) begin
                    hit_b = 1'b1;
`ifdef RF_BYPASS_EN
                    byp_b = queue_q[i].val;
`endif
                end
            end
        end
        if (init_done && srcA != REG_NONE) begin
`ifdef RF_BYPASS_EN
            valA = hit_a ? byp_a : regs_q[srcA];
`else
            valA        = regs_q[srcA];
            rd_hazard_a = hit_a;
`endif
        end
        if (init_done && srcB != REG_NONE) begin
`ifdef RF_BYPASS_EN
            valB = hit_b ? byp_b : regs_q[srcB];
`else
            valB        = regs_q[srcB];
            rd_hazard_b = hit_b;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_sched
//
// Directed bench for regfile_wb_sched with DEPTH = 4. Inputs change and
// outputs are sampled 1 time unit after each rising edge. Expected values are
// hand-derived; the sustained-write section tracks occupancy with a small
// counter model. Works with and without RF_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_wb_sched;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        wb_valid_e;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic        wb_valid_m;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic        wb_ready;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        rd_hazard_a;
    logic        rd_hazard_b;
    logic        init_done;
    logic [3:0]  pend_cnt;

    int tests  = 0;
    int failed = 0;

    regfile_wb_sched #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_valid_e  (wb_valid_e),
        .dstE        (dstE),
        .valE        (valE),
        .wb_valid_m  (wb_valid_m),
        .dstM        (dstM),
        .valM        (valM),
        .wb_ready    (wb_ready),
        .srcA        (srcA),
        .srcB        (srcB),
        .valA        (valA),
        .valB        (valB),
        .rd_hazard_a (rd_hazard_a),
        .rd_hazard_b (rd_hazard_b),
        .init_done   (init_done),
        .pend_cnt    (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_e(input logic v, input logic [3:0] d, input logic [63:0] x);
        wb_valid_e = v;
        dstE       = d;
        valE       = x;
    endtask

    task automatic drive_m(input logic v, input logic [3:0] d, input logic [63:0] x);
        wb_valid_m = v;
        dstM       = d;
        valM       = x;
    endtask

    // Sustained dual-write stimulus: pair p writes E to pair_de[p], M to pair_dm[p].
    logic [3:0] pair_de [4] = '{4'd6, 4'd8, 4'd10, 4'd12};
    logic [3:0] pair_dm [4] = '{4'd7, 4'd9, 4'd11, 4'd6};
    logic [3:0] fin_reg [7] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    logic [63:0] fin_val [7] = '{64'h107, 64'h101, 64'h102, 64'h103,
                                 64'h104, 64'h105, 64'h106};

    initial begin
        int exp_cnt;
        int p;
        bit exp_ready;

        rst_n = 1'b0;
        drive_e(1'b0, 4'hF, 64'h0);
        drive_m(1'b0, 4'hF, 64'h0);
        srcA = 4'd3;
        srcB = 4'hF;

        // ---- Reset state ----
        step();
        step();
        check("rst_wb_ready",  64'(wb_ready),    64'h0);
        check("rst_init_done", 64'(init_done),   64'h0);
        check("rst_pend_cnt",  64'(pend_cnt),    64'h0);
        check("rst_valA",      valA,             64'h0);
        check("rst_valB",      valB,             64'h0);
        check("rst_hazard_a",  64'(rd_hazard_a), 64'h0);
        check("rst_hazard_b",  64'(rd_hazard_b), 64'h0);

        // ---- Clear sweep: init_done rises on the 15th edge ----
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            check("init_done_low", 64'(init_done), 64'h0);
            check("init_valA",     valA,           64'h0);
            check("init_wb_ready", 64'(wb_ready),  64'h0);
        end
        step();
        check("init_done_high", 64'(init_done), 64'h1);
        check("run_wb_ready",   64'(wb_ready),  64'h1);
        check("run_valA_r3",    valA,           64'h0);

        // ---- Single E write, dst 2 ----
        srcA = 4'd2;
        drive_e(1'b1, 4'd2, 64'hAA);
        check("same_cycle_no_fwd", valA, 64'h0);
        step();
        drive_e(1'b0, 4'hF, 64'h0);
        check("e2_pend_t1", 64'(pend_cnt), 64'h1);
`ifdef RF_BYPASS_EN
        check("e2_bypass_t1", valA,             64'hAA);
        check("e2_hazard_t1", 64'(rd_hazard_a), 64'h0);
`else
        check("e2_store_t1",  valA,             64'h0);
        check("e2_hazard_t1", 64'(rd_hazard_a), 64'h1);
`endif
        step();
        check("e2_pend_t2",   64'(pend_cnt),    64'h0);
        check("e2_valA_t2",   valA,             64'hAA);
        check("e2_hazard_t2", 64'(rd_hazard_a), 64'h0);

        // ---- Same-cycle E and M to register 4: M wins ----
        srcA = 4'd4;
        drive_e(1'b1, 4'd4, 64'h10);
        drive_m(1'b1, 4'd4, 64'h20);
        step();
        drive_e(1'b0, 4'hF, 64'h0);
        drive_m(1'b0, 4'hF, 64'h0);
        check("em4_pend_2", 64'(pend_cnt), 64'h2);
`ifdef RF_BYPASS_EN
        check("em4_bypass_young", valA, 64'h20);
`else
        check("em4_store_old", valA,             64'h0);
        check("em4_hazard",    64'(rd_hazard_a), 64'h1);
`endif
        step();
        check("em4_pend_1", 64'(pend_cnt), 64'h1);
`ifdef RF_BYPASS_EN
        check("em4_bypass_m", valA, 64'h20);
`else
        check("em4_store_e", valA, 64'h10);
`endif
        step();
        check("em4_pend_0", 64'(pend_cnt), 64'h0);
        check("em4_final",  valA,          64'h20);

        // ---- dst 4'hF discarded; srcB 4'hF reads 0 ----
        srcA = 4'd2;
        srcB = 4'hF;
        drive_e(1'b1, 4'hF, 64'hDEAD);
        step();
        drive_e(1'b0, 4'hF, 64'h0);
        check("none_pend_cnt", 64'(pend_cnt), 64'h0);
        check("none_valB",     valB,          64'h0);
        check("none_valA_r2",  valA,          64'hAA);

        // ---- Sustained dual writes: backpressure, no loss, order kept ----
        exp_cnt = 0;
        p = 0;
        for (int cyc = 0; cyc < 20 && p < 4; cyc++) begin
            exp_ready = (exp_cnt <= DEPTH - 2);
            check("dual_pend_cnt", 64'(pend_cnt), 64'(exp_cnt));
            check("dual_wb_ready", 64'(wb_ready), 64'(exp_ready));
            drive_e(1'b1, pair_de[p], 64'h100 + 64'(2 * p));
            drive_m(1'b1, pair_dm[p], 64'h101 + 64'(2 * p));
            step();
            exp_cnt = exp_cnt - ((exp_cnt > 0) ? 1 : 0) + (exp_ready ? 2 : 0);
            if (exp_ready) p++;
        end
        check("dual_all_issued", 64'(p), 64'h4);
        drive_e(1'b0, 4'hF, 64'h0);
        drive_m(1'b0, 4'hF, 64'h0);
        check("dual_peak_cnt", 64'(pend_cnt), 64'h3);
        for (int cyc = 0; cyc < 3; cyc++) step();
        check("dual_drained", 64'(pend_cnt), 64'h0);
        for (int r = 0; r < 7; r++) begin
            srcA = fin_reg[r];
            #1;
            check("dual_final_reg", valA, fin_val[r]);
        end

        // ---- Reset with 3 entries pending ----
        drive_e(1'b1, 4'd1, 64'h55);
        drive_m(1'b1, 4'd2, 64'h66);
        step();
        drive_e(1'b1, 4'd3, 64'h77);
        drive_m(1'b1, 4'd5, 64'h88);
        step();
        drive_e(1'b0, 4'hF, 64'h0);
        drive_m(1'b0, 4'hF, 64'h0);
        check("prerst_pend_3", 64'(pend_cnt), 64'h3);
        rst_n = 1'b0;
        step();
        check("midrst_pend_cnt",  64'(pend_cnt),  64'h0);
        check("midrst_init_done", 64'(init_done), 64'h0);
        check("midrst_wb_ready",  64'(wb_ready),  64'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) step();
        check("reinit_done_low", 64'(init_done), 64'h0);
        step();
        check("reinit_done_high", 64'(init_done), 64'h1);
        for (int r = 0; r < 15; r++) begin
            srcA = 4'(r);
            #1;
            check("reinit_reg_zero", valA, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
